// File: rtl/seg_display_scan_if.sv
// -----------------------------------------------------------------------------
// seg_display_scan_if
// Bundle between the alarm-clock digit register bank and the multiplexed
// seven-segment display driver.
//
// Signals
//   digits      [15:0] BCD digits, [3:0] = rightmost digit 0, [15:12] = digit 3
//   dp          [3:0]  decimal point request per digit, active-high
//   blink_mask  [3:0]  digits to blink, active-high
//   en                 display enable, active-high
//   seg         [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp_n               decimal point, active-low
//   an          [3:0]  digit anodes, active-low, at most one bit low
//   frame_start        one-cycle pulse when a new snapshot is taken
//
// Modports
//   master : register-bank / board side (drives digit data, observes pins)
//   slave  : display driver
// -----------------------------------------------------------------------------
interface seg_display_scan_if;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic        en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output digits, dp, blink_mask, en,
        input  seg, dp_n, an, frame_start
    );

    modport slave (
        input  digits, dp, blink_mask, en,
        output seg, dp_n, an, frame_start
    );
endinterface

// File: rtl/seg_display_scan.sv
// -----------------------------------------------------------------------------
// seg_display_scan
// Multiplexed four-digit seven-segment display driver. The BCD digits are
// snapshotted once per scan frame (at the idx 3->0 wrap) so a digit update
// arriving mid-frame never tears the display; one digit at a time is then
// driven through registered active-low anode and segment lines.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (2 .. 2^20)
//   BLINK_FRAMES  frames per blink half-period (1 .. 1023), blink builds only
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   seg_display_scan_if.slave (digit data in, display pins out)
//
// Optional feature
//   SEG_SCAN_BLINK_EN  when defined, digits selected by the snapshotted
//                      blink_mask are blanked on alternate BLINK_FRAMES-frame
//                      periods. When undefined, blink_mask is ignored.
// -----------------------------------------------------------------------------
module seg_display_scan #(
    parameter int unsigned SCAN_DIV     = 32'd50000,
    parameter int unsigned BLINK_FRAMES = 32'd64
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_scan_if.slave  bus
);

    localparam int unsigned    CNT_W   = (SCAN_DIV > 32'd1) ? $clog2(SCAN_DIV) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 32'd1);

    // Active-low seven-segment decode; codes A-F blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_snap;
    logic [3:0]       r_dp_snap;

    logic             w_tick;
    logic             w_wrap;
    logic             w_blink_blank;
    logic [3:0]       w_nibble;

    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_n_nxt;
    logic             w_fs_nxt;

    assign w_tick   = (r_cnt == CNT_MAX);
    // The frame boundary: last cycle of digit 3's slot.
    assign w_wrap   = w_tick && (r_idx == 2'd3);
    assign w_nibble = r_snap[{r_idx, 2'b00} +: 4];

    // Prescaler and digit index; both freeze while the display is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
            r_idx <= 2'd0;
        end else if (bus.en) begin
            if (w_tick) begin
                r_cnt <= {CNT_W{1'b0}};
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1'b1);
            end
        end
    end

    // Frame snapshot of digit data, taken only at the idx 3->0 wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap    <= 16'h0000;
            r_dp_snap <= 4'b0000;
        end else if (bus.en && w_wrap) begin
            r_snap    <= bus.digits;
            r_dp_snap <= bus.dp;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned     FC_W   = (BLINK_FRAMES > 32'd1) ? $clog2(BLINK_FRAMES) : 32'd1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_FRAMES - 32'd1);

    logic [3:0]      r_mask_snap;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_phase;

    // Blink mask snapshot and frame counter; the phase flips at the same wrap
    // edge that starts the new frame so a whole frame shares one phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask_snap <= 4'b0000;
            r_frame_cnt <= {FC_W{1'b0}};
            r_phase     <= 1'b0;
        end else if (bus.en && w_wrap) begin
            r_mask_snap <= bus.blink_mask;
            if (r_frame_cnt == FC_MAX) begin
                r_frame_cnt <= {FC_W{1'b0}};
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + FC_W'(1'b1);
            end
        end
    end

    assign w_blink_blank = r_phase & r_mask_snap[r_idx];
`else
    logic w_unused_blink;

    // Blink is not built: the mask input and blink period are intentionally unused.
    assign w_unused_blink = ^{bus.blink_mask, BLINK_FRAMES[0]};
    assign w_blink_blank  = 1'b0;
`endif

    // Next values for the display pins from the current index and snapshot.
    always_comb begin
        w_an_nxt   = 4'b1111;
        w_seg_nxt  = 7'h7F;
        w_dp_n_nxt = 1'b1;
        w_fs_nxt   = 1'b0;
        if (bus.en) begin
            w_an_nxt = ~(4'b0001 << r_idx);
            w_fs_nxt = w_wrap;
            if (w_blink_blank) begin
                w_seg_nxt  = 7'h7F;
                w_dp_n_nxt = 1'b1;
            end else begin
                w_seg_nxt  = seg_decode(w_nibble);
                w_dp_n_nxt = ~r_dp_snap[r_idx];
            end
        end else begin
            w_an_nxt   = 4'b1111;
            w_seg_nxt  = 7'h7F;
            w_dp_n_nxt = 1'b1;
            w_fs_nxt   = 1'b0;
        end
    end

    // Registered display pins and frame_start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.an          <= 4'b1111;
            bus.seg         <= 7'h7F;
            bus.dp_n        <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= w_an_nxt;
            bus.seg         <= w_seg_nxt;
            bus.dp_n        <= w_dp_n_nxt;
            bus.frame_start <= w_fs_nxt;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scan
// Self-checking bench for seg_display_scan. A reference model tracks the number
// of enabled clock edges since reset and derives slot, frame, snapshot and blink
// phase from it arithmetically. Blink expectations follow SEG_SCAN_BLINK_EN.
// -----------------------------------------------------------------------------
module tb_seg_display_scan;

    localparam int unsigned SD    = 4;
    localparam int unsigned BF    = 2;
    localparam int          FRAME = 4 * SD;

    logic clk;
    logic rst;

    seg_display_scan_if u_if ();

    seg_display_scan #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16];

    // Reference model state
    int          m_cnt;
    logic [15:0] m_digits;
    logic [3:0]  m_dp;
    logic [3:0]  m_mask;

    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic        e_fs;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_pins(input string tag);
        check_val({tag, "_an"},   {28'd0, u_if.an},          {28'd0, e_an});
        check_val({tag, "_seg"},  {25'd0, u_if.seg},         {25'd0, e_seg});
        check_val({tag, "_dpn"},  {31'd0, u_if.dp_n},        {31'd0, e_dpn});
        check_val({tag, "_fs"},   {31'd0, u_if.frame_start}, {31'd0, e_fs});
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_digits = 16'h0000;
        m_dp     = 4'b0000;
        m_mask   = 4'b0000;
        e_an     = 4'b1111;
        e_seg    = 7'h7F;
        e_dpn    = 1'b1;
        e_fs     = 1'b0;
    endtask

    // One clock edge: predict from pre-edge inputs, then compare just after.
    task automatic step();
        int   slot;
        int   frame;
        logic blank;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (!u_if.en) begin
            e_an  = 4'b1111;
            e_seg = 7'h7F;
            e_dpn = 1'b1;
            e_fs  = 1'b0;
        end else begin
            slot  = (m_cnt / SD) % 4;
            frame = m_cnt / FRAME;
            blank = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            blank = m_mask[slot] && (((frame / BF) % 2) == 1);
`endif
            e_an       = 4'b1111;
            e_an[slot] = 1'b0;
            if (blank) begin
                e_seg = 7'h7F;
                e_dpn = 1'b1;
            end else begin
                e_seg = seg_tab[m_digits[4*slot +: 4]];
                e_dpn = ~m_dp[slot];
            end
            e_fs = (((m_cnt + 1) % FRAME) == 0);
            if (e_fs) begin
                m_digits = u_if.digits;
                m_dp     = u_if.dp;
                m_mask   = u_if.blink_mask;
            end
            m_cnt++;
        end
        #1;
        check_pins("scan");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model sits at a given slot and offset within it.
    task automatic goto_slot(input int slot, input int off);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((((m_cnt % FRAME) / SD) == slot) && ((m_cnt % SD) == off)) break;
            step();
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        model_reset();

        rst             = 1'b0;
        u_if.en         = 1'b1;
        u_if.digits     = 16'h1234;
        u_if.dp         = 4'b0100;
        u_if.blink_mask = 4'b0001;

        // Reset values while rst is held low
        #12;
        check_pins("reset");
        run(2);
        @(negedge clk);
        rst = 1'b1;

        // First frame from the zero snapshot, then two frames of 1234h
        run(3 * FRAME + 4);

        // Snapshot isolation: change data during slot 1
        goto_slot(1, 1);
        u_if.digits = 16'h5678;
        run(2 * FRAME);

        // Invalid code on digit 1
        u_if.digits = 16'h00A0;
        u_if.dp     = 4'b0000;
        run(2 * FRAME);

        // Enable dropped during slot 2 for 10 cycles
        goto_slot(2, 1);
        u_if.en = 1'b0;
        run(10);
        u_if.en = 1'b1;
        run(FRAME + 4);

        // Randomized traffic including enable gaps and A-F codes
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 7) == 0)  u_if.digits     = 16'($urandom);
            if ($urandom_range(0, 15) == 0) u_if.dp         = 4'($urandom);
            if ($urandom_range(0, 15) == 0) u_if.blink_mask = 4'($urandom);
            if ($urandom_range(0, 19) == 0) u_if.en         = ~u_if.en;
        end
        u_if.en = 1'b1;
        run(FRAME);

        // Asynchronous reset mid-operation acts without a clock edge
        goto_slot(2, 2);
        #2;
        rst = 1'b0;
        #1;
        e_an  = 4'b1111;
        e_seg = 7'h7F;
        e_dpn = 1'b1;
        e_fs  = 1'b0;
        check_pins("async_rst");
        run(3);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if ($urandom_range(0, 5) == 0)  u_if.digits     = 16'($urandom);
            if ($urandom_range(0, 9) == 0)  u_if.dp         = 4'($urandom);
            if ($urandom_range(0, 9) == 0)  u_if.blink_mask = 4'($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
